// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals shared by mem_arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_data;
   logic        if_ack;

   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_sel;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;

   logic        mem_ce;
   logic        mem_we;
   logic [3:0]  mem_sel;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic        stallreq;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_sel, dm_addr, dm_wdata, mem_rdata,
      output if_data, if_ack, dm_rdata, dm_ack,
      output mem_ce, mem_we, mem_sel, mem_addr, mem_wdata, stallreq
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_sel, dm_addr, dm_wdata, mem_rdata,
      input  if_data, if_ack, dm_rdata, dm_ack,
      input  mem_ce, mem_we, mem_sel, mem_addr, mem_wdata, stallreq
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle single-ported memory between instruction fetch and data access.
// state   | meaning
// IDLE    | no access in flight; grants an eligible requester (also the ack cycle)
// BUSY_IF | fetch owns the memory, mem_ce held while the wait counter runs down
// BUSY_DM | data port owns the memory, mem_ce held while the wait counter runs down
module mem_arbiter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  arb
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic        r_last_grant;

   logic        r_mem_ce;
   logic        r_mem_we;
   logic [3:0]  r_mem_sel;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic        r_if_ack;
   logic        r_dm_ack;
   logic [31:0] r_if_data;
   logic [31:0] r_dm_rdata;

   logic        w_if_elig;
   logic        w_dm_elig;
   logic        w_grant_if;
   logic        w_grant_dm;
   logic        w_done;

   // A request still high during its own ack cycle is the old one, not a new one.
   assign w_if_elig = arb.if_req & ~r_if_ack;
   assign w_dm_elig = arb.dm_req & ~r_dm_ack;

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_grant_dm)      w_state_nxt = BUSY_DM;
            else if (w_grant_if) w_state_nxt = BUSY_IF;
         end
         BUSY_IF, BUSY_DM: begin
            if (r_cnt == 4'd0) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Contention favours DM unless DM won last time, so the ports alternate.
   always_comb begin
      w_grant_dm = 1'b0;
      w_grant_if = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         IDLE: begin
            w_grant_dm = w_dm_elig & (~w_if_elig | ~r_last_grant);
            w_grant_if = w_if_elig & ~w_grant_dm;
         end
         BUSY_IF, BUSY_DM: w_done = (r_cnt == 4'd0);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= 4'd0;
         r_last_grant <= 1'b0;
         r_mem_ce     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_sel    <= 4'd0;
         r_mem_addr   <= 32'd0;
         r_mem_wdata  <= 32'd0;
         r_if_ack     <= 1'b0;
         r_dm_ack     <= 1'b0;
         r_if_data    <= 32'd0;
         r_dm_rdata   <= 32'd0;
      end else begin
         r_if_ack <= 1'b0;
         r_dm_ack <= 1'b0;
         if (w_grant_dm || w_grant_if) begin
            r_mem_ce     <= 1'b1;
            r_mem_we     <= w_grant_dm & arb.dm_we;
            r_mem_sel    <= w_grant_dm ? arb.dm_sel   : 4'hF;
            r_mem_addr   <= w_grant_dm ? arb.dm_addr  : arb.if_addr;
            r_mem_wdata  <= w_grant_dm ? arb.dm_wdata : 32'd0;
            r_cnt        <= CNT_LOAD;
            r_last_grant <= w_grant_dm;
         end else if (w_done) begin
            r_mem_ce    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_sel   <= 4'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            if (r_state == BUSY_IF) begin
               r_if_data <= arb.mem_rdata;
               r_if_ack  <= 1'b1;
            end else begin
               if (!r_mem_we) r_dm_rdata <= arb.mem_rdata;
               r_dm_ack <= 1'b1;
            end
         end else if (r_state != IDLE) begin
            r_cnt <= r_cnt - 4'd1;
         end
      end
   end

   assign arb.mem_ce    = r_mem_ce;
   assign arb.mem_we    = r_mem_we;
   assign arb.mem_sel   = r_mem_sel;
   assign arb.mem_addr  = r_mem_addr;
   assign arb.mem_wdata = r_mem_wdata;
   assign arb.if_ack    = r_if_ack;
   assign arb.dm_ack    = r_dm_ack;
   assign arb.if_data   = r_if_data;
   assign arb.dm_rdata  = r_dm_rdata;
   assign arb.stallreq  = (arb.if_req & ~r_if_ack) | (arb.dm_req & ~r_dm_ack);

endmodule
